sd_sector_responder: RTL and testbench
======================================

# sd_sector_responder

Block-device responder for the core's backup-RAM save/load sequencer. It answers the sector protocol (`sd_lba`, `sd_rd`, `sd_wr`, `sd_ack`, `sd_buff_*`) from the device side, so the core can run its existing save/load logic against a local word store with no host in the loop. It sits between the sequencer/BSRAM port B and a simple request/ready memory port, such as an SDRAM channel or a BRAM wrapper.

## Interface
- `LBA_BITS`, 6: sector index width; the store holds 2^LBA_BITS sectors of 256 16-bit words.
- `SECTORS`, 64: number of valid sectors reported as the image size; must be ≤ 2^LBA_BITS.
- `clk_sys` input 1: the single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `mount` input 1: a rising edge announces the image.
- `img_mounted` output 1: one-cycle pulse.
- `img_size` output 64: constant SECTORS*512.
- `img_readonly` output 1: constant 0.
- `sd_lba` input 32: requested sector.
- `sd_rd` input 1: read request, level.
- `sd_wr` input 1: write request, level.
- `sd_ack` output 1: high for the whole sector transfer.
- `sd_buff_addr` output 8: word index within the sector.
- `sd_buff_dout` output 16: read data toward the requester.
- `sd_buff_wr` output 1: read-data strobe.
- `sd_buff_din` input 16: write data from the requester's buffer; valid 1 cycle after `sd_buff_addr`.
- `mem_addr` output LBA_BITS+8: word address {lba, index}.
- `mem_rd` output 1: read strobe, held until `mem_ready`.
- `mem_wr` output 1: write strobe, held until `mem_ready`.
- `mem_din` output 16: write data.
- `mem_dout` input 16: read data, valid with `mem_ready`.
- `mem_ready` input 1: completes the current access.

## Operation
- States: IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_LATCH, WR_REQ, FINISH.
- **IDLE → transfer**
  - When `sd_rd` or `sd_wr` is high, latch `sd_lba[LBA_BITS-1:0]`, set index to 0 and raise `sd_ack`.
  - If `sd_rd` is high, go to RD_REQ. Otherwise go to WR_ADDR.
  - Read wins if both requests are high.
- **Read path**
  - RD_REQ: drive `mem_rd`=1 and `mem_addr`={lba, index}. On `mem_ready`, capture `mem_dout` and go to RD_PUT.
  - RD_PUT: drive `sd_buff_addr`=index, `sd_buff_dout`=captured word and `sd_buff_wr`=1 for one cycle.
  - After RD_PUT, if index==255 go to FINISH; otherwise increment index and return to RD_REQ.
- **Write path**
  - WR_ADDR: drive `sd_buff_addr`=index.
  - WR_LATCH: capture `sd_buff_din`.
  - WR_REQ: drive `mem_wr`=1 with `mem_din`=captured word. On `mem_ready`, if index==255 go to FINISH; otherwise increment index and go to WR_ADDR.
- **FINISH**: drop `sd_ack` and return to IDLE. The requester's new request is accepted from the following cycle.
- Requests that drop while `sd_ack` is high are ignored. The sector always completes all 256 words.
- A `mount` rising edge, detected with a registered previous value, produces an `img_mounted` pulse the next cycle. This works in any state.
- Index is 8 bits and wraps only at the sector end.
- `mem_addr` is concatenated, never added.

## Timing
- Reset values: `sd_ack`, `sd_buff_wr`, `mem_rd`, `mem_wr` and `img_mounted` = 0. `sd_buff_addr`, `sd_buff_dout`, `mem_addr` and `mem_din` = 0. State = IDLE.
- Reset mid-transfer aborts at once: strobes and `sd_ack` go low the cycle after `reset` is sampled high.
- `sd_ack` rises 1 cycle after the request is sampled in IDLE.
- Read word cost: cycles to `mem_ready` + 1. With `mem_ready` constantly high, one word every 2 cycles.
- Write word cost: 2 + cycles to `mem_ready`. With ready constantly high, one word every 3 cycles.
- `sd_ack` falls 1 cycle after the last word's `mem_ready` (write) or `sd_buff_wr` (read).
- `mem_rd` and `mem_wr` are never high together.
- `mem_addr` and `mem_din` are stable while a strobe is high.

## Configuration
- `SD_SECTOR_RANGE_CHECK_EN` defined:
  - Requests with `sd_lba` ≥ SECTORS still run the full handshake but issue no `mem_rd`/`mem_wr`.
  - Reads return 16'h0000 on every `sd_buff_wr`. Writes are discarded.
  - Timing matches a transfer with `mem_ready`=1.
- Undefined: `sd_lba` is truncated to LBA_BITS bits and the access wraps into the store.

## Test plan
- **Reset and idle**: hold `reset` high for 3 cycles, then release with no request → all outputs 0 and no memory strobes for 100 cycles.
- **Single read**: store word n = 16'hA500+n in sector 3 and pulse `sd_rd` with `sd_lba`=3, `mem_ready`=1 → `sd_ack` high for 512 cycles, 256 `sd_buff_wr` pulses with addr n and data 16'hA500+n, `mem_addr` runs {3,0}..{3,255}.
- **Single write with stalls**: buffer holds 16'h1234^n and `mem_ready` asserts 2 cycles after each strobe; write `sd_lba`=5 → memory words {5,n} = 16'h1234^n, `sd_ack` falls after the 256th ready.
- **Back-to-back sectors**: requester re-raises `sd_rd` on the cycle `sd_ack` falls, for sectors 0..3 → 4 complete transfers, no gap beyond 1 IDLE cycle, no dropped words.
- **Reset mid-read**: assert `reset` at word 100 → `sd_ack`/`mem_rd` low next cycle. A fresh read of sector 1 afterwards starts at index 0.
- **Range and mount**: with `SD_SECTOR_RANGE_CHECK_EN` and SECTORS=64, read `sd_lba`=64 → 256 zero words and no `mem_rd`. A `mount` edge → one-cycle `img_mounted` with `img_size`=32768.

Source files
------------

// File: rtl/sd_sector_responder.sv
// sd_sector_responder: device-side responder for the sd_lba/sd_rd/sd_wr/sd_ack
// sector protocol, backed by a request/ready word memory holding 2^LBA_BITS
// sectors of 256 16-bit words.
// Optional feature macro: SD_SECTOR_RANGE_CHECK_EN (requests with
// sd_lba >= SECTORS run the handshake without touching memory).
module sd_sector_responder #(
    parameter int unsigned LBA_BITS = 6,
    parameter int unsigned SECTORS  = 64
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  mount,
    output logic                  img_mounted,
    output logic [63:0]           img_size,
    output logic                  img_readonly,
    input  logic [31:0]           sd_lba,
    input  logic                  sd_rd,
    input  logic                  sd_wr,
    output logic                  sd_ack,
    output logic [7:0]            sd_buff_addr,
    output logic [15:0]           sd_buff_dout,
    output logic                  sd_buff_wr,
    input  logic [15:0]           sd_buff_din,
    output logic [LBA_BITS+7:0]   mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [15:0]           mem_din,
    input  logic [15:0]           mem_dout,
    input  logic                  mem_ready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_PUT,
        WR_ADDR,
        WR_LATCH,
        WR_REQ,
        FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [LBA_BITS-1:0] lba_q, lba_d;
    logic [7:0]          idx_q, idx_d;
    logic [15:0]         data_q, data_d;
    logic                skip_q, skip_d;
    logic                mount_q;
    logic                mounted_q;
    logic                req_oor;

`ifdef SD_SECTOR_RANGE_CHECK_EN
    assign req_oor = (sd_lba >= 32'(SECTORS));
`else
    // Upper LBA bits are dropped: the access wraps into the store.
    logic unused_lba_hi;
    assign unused_lba_hi = ^sd_lba[31:LBA_BITS];
    assign req_oor       = 1'b0;
`endif

    // State, transfer registers and mount edge detector.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            lba_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            skip_q    <= 1'b0;
            mount_q   <= 1'b0;
            mounted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lba_q     <= lba_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            skip_q    <= skip_d;
            mount_q   <= mount;
            mounted_q <= mount & ~mount_q;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d    = state_q;
        lba_d      = lba_q;
        idx_d      = idx_q;
        data_d     = data_q;
        skip_d     = skip_q;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (sd_rd || sd_wr) begin
                    lba_d   = sd_lba[LBA_BITS-1:0];
                    idx_d   = '0;
                    skip_d  = req_oor;
                    state_d = sd_rd ? RD_REQ : WR_ADDR;
                end
            end
            RD_REQ: begin
                sd_ack = 1'b1;
                mem_rd = ~skip_q;
                // A skipped (out-of-range) word behaves as if memory were ready.
                if (skip_q) begin
                    data_d  = '0;
                    state_d = RD_PUT;
                end else if (mem_ready) begin
                    data_d  = mem_dout;
                    state_d = RD_PUT;
                end
            end
            RD_PUT: begin
                sd_ack     = 1'b1;
                sd_buff_wr = 1'b1;
                if (idx_q == 8'hFF) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = RD_REQ;
                end
            end
            WR_ADDR: begin
                sd_ack  = 1'b1;
                state_d = WR_LATCH;
            end
            WR_LATCH: begin
                sd_ack  = 1'b1;
                data_d  = sd_buff_din;
                state_d = WR_REQ;
            end
            WR_REQ: begin
                sd_ack = 1'b1;
                mem_wr = ~skip_q;
                if (skip_q || mem_ready) begin
                    if (idx_q == 8'hFF) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = WR_ADDR;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sd_buff_addr = idx_q;
    assign sd_buff_dout = data_q;
    assign mem_addr     = {lba_q, idx_q};
    assign mem_din      = data_q;
    assign img_mounted  = mounted_q;
    assign img_size     = 64'(SECTORS) * 64'd512;
    assign img_readonly = 1'b0;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Directed testbench for sd_sector_responder with a request/ready memory model
// (programmable stall) and a requester buffer model for write data.
module tb_sd_sector_responder;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        mount   = 1'b0;
    logic        img_mounted;
    logic [63:0] img_size;
    logic        img_readonly;
    logic [31:0] sd_lba  = '0;
    logic        sd_rd   = 1'b0;
    logic        sd_wr   = 1'b0;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din = '0;
    logic [13:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_ready;

    logic [15:0] mem  [0:16383];
    logic [15:0] wbuf [0:255];
    int unsigned mem_stall = 0;
    int unsigned mem_cnt   = 0;
    int          total     = 0;
    int          bad       = 0;

    sd_sector_responder #(.LBA_BITS(6), .SECTORS(64)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .mount        (mount),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .img_readonly (img_readonly),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .mem_ready    (mem_ready)
    );

    always #5 clk_sys = ~clk_sys;

    // Memory answers after mem_stall cycles of a held strobe.
    assign mem_ready = (mem_rd | mem_wr) && (mem_cnt >= mem_stall);
    assign mem_dout  = mem_ready ? mem[mem_addr] : 16'hDEAD;

    // Stall counter and requester buffer (data one cycle after address).
    always @(posedge clk_sys) begin
        if ((mem_rd | mem_wr) && !mem_ready) mem_cnt <= mem_cnt + 1;
        else                                 mem_cnt <= 0;
        sd_buff_din <= wbuf[sd_buff_addr];
    end

    task automatic do_read(input logic [31:0] lba, input bit want_zero,
                           output int unsigned gap, output int unsigned ackc,
                           output int unsigned nput, output int unsigned nrd,
                           output int unsigned derr, output int unsigned aerr,
                           output int unsigned both);
        logic [5:0]  l6;
        logic [15:0] expw;
        l6 = lba[5:0];
        gap = 0; ackc = 0; nput = 0; nrd = 0; derr = 0; aerr = 0; both = 0;
        sd_lba = lba;
        sd_rd  = 1'b1;
        while (!sd_ack && gap < 20) begin
            @(posedge clk_sys); @(negedge clk_sys); gap++;
        end
        sd_rd = 1'b0;
        while (sd_ack && ackc < 4000) begin
            if (sd_buff_wr) begin
                expw = want_zero ? 16'h0000 : mem[{l6, nput[7:0]}];
                if (sd_buff_addr !== nput[7:0] || sd_buff_dout !== expw) derr++;
                nput++;
            end
            if (mem_rd) begin
                nrd++;
                if (mem_addr !== {l6, nput[7:0]}) aerr++;
            end
            if (mem_wr) both++;
            ackc++;
            @(negedge clk_sys);
        end
    endtask

    task automatic do_write(input logic [31:0] lba,
                            output int unsigned gap, output int unsigned ackc,
                            output int unsigned nrdy, output int unsigned last_rdy,
                            output int unsigned nwrc, output int unsigned derr,
                            output int unsigned nrd);
        logic [5:0] l6;
        l6 = lba[5:0];
        gap = 0; ackc = 0; nrdy = 0; last_rdy = 0; nwrc = 0; derr = 0; nrd = 0;
        sd_lba = lba;
        sd_wr  = 1'b1;
        while (!sd_ack && gap < 20) begin
            @(posedge clk_sys); @(negedge clk_sys); gap++;
        end
        sd_wr = 1'b0;
        while (sd_ack && ackc < 8000) begin
            if (mem_rd) nrd++;
            if (mem_wr) begin
                nwrc++;
                if (mem_addr !== {l6, nrdy[7:0]} || mem_din !== wbuf[nrdy[7:0]]) derr++;
                if (mem_ready) begin
                    mem[mem_addr] = mem_din;
                    last_rdy = ackc;
                    nrdy++;
                end
            end
            ackc++;
            @(negedge clk_sys);
        end
    endtask

    task automatic test_reset();
        int unsigned busy;
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        total++; if ({sd_ack, sd_buff_wr, mem_rd, mem_wr, img_mounted} !== 5'b0) begin
            bad++; $display("FAIL reset_strobes got=%b want=00000", {sd_ack, sd_buff_wr, mem_rd, mem_wr, img_mounted}); end
        total++; if (sd_buff_addr !== 8'h00) begin
            bad++; $display("FAIL reset_buff_addr got=%h want=00", sd_buff_addr); end
        total++; if (sd_buff_dout !== 16'h0000) begin
            bad++; $display("FAIL reset_buff_dout got=%h want=0000", sd_buff_dout); end
        total++; if (mem_addr !== 14'h0000) begin
            bad++; $display("FAIL reset_mem_addr got=%h want=0000", mem_addr); end
        total++; if (mem_din !== 16'h0000) begin
            bad++; $display("FAIL reset_mem_din got=%h want=0000", mem_din); end
        total++; if (img_readonly !== 1'b0) begin
            bad++; $display("FAIL reset_readonly got=%b want=0", img_readonly); end
        reset = 1'b0;
        busy  = 0;
        repeat (100) begin
            @(negedge clk_sys);
            if (sd_ack | sd_buff_wr | mem_rd | mem_wr | img_mounted) busy++;
        end
        total++; if (busy !== 0) begin
            bad++; $display("FAIL idle_activity got=%0d want=0", busy); end
    endtask

    task automatic test_single_read();
        int unsigned gap, ackc, nput, nrd, derr, aerr, both;
        for (int n = 0; n < 256; n++) mem[(3 << 8) + n] = 16'hA500 + 16'(n);
        mem_stall = 0;
        do_read(32'd3, 1'b0, gap, ackc, nput, nrd, derr, aerr, both);
        total++; if (gap !== 1) begin bad++; $display("FAIL rd_ack_latency got=%0d want=1", gap); end
        total++; if (ackc !== 512) begin bad++; $display("FAIL rd_ack_cycles got=%0d want=512", ackc); end
        total++; if (nput !== 256) begin bad++; $display("FAIL rd_puts got=%0d want=256", nput); end
        total++; if (derr !== 0) begin bad++; $display("FAIL rd_data_errs got=%0d want=0", derr); end
        total++; if (nrd !== 256) begin bad++; $display("FAIL rd_mem_rd_cycles got=%0d want=256", nrd); end
        total++; if (aerr !== 0) begin bad++; $display("FAIL rd_addr_errs got=%0d want=0", aerr); end
        total++; if (both !== 0) begin bad++; $display("FAIL rd_mem_wr_seen got=%0d want=0", both); end
    endtask

    task automatic test_write_stall();
        int unsigned gap, ackc, nrdy, last_rdy, nwrc, derr, nrd, merr;
        for (int n = 0; n < 256; n++) wbuf[n] = 16'h1234 ^ 16'(n);
        mem_stall = 2;
        repeat (2) @(negedge clk_sys);
        do_write(32'd5, gap, ackc, nrdy, last_rdy, nwrc, derr, nrd);
        merr = 0;
        for (int n = 0; n < 256; n++) if (mem[(5 << 8) + n] !== (16'h1234 ^ 16'(n))) merr++;
        total++; if (gap !== 1) begin bad++; $display("FAIL wr_ack_latency got=%0d want=1", gap); end
        total++; if (ackc !== 1280) begin bad++; $display("FAIL wr_ack_cycles got=%0d want=1280", ackc); end
        total++; if (nrdy !== 256) begin bad++; $display("FAIL wr_ready_count got=%0d want=256", nrdy); end
        total++; if (last_rdy !== 1279) begin bad++; $display("FAIL wr_ack_fall got=%0d want=1279", last_rdy); end
        total++; if (nwrc !== 768) begin bad++; $display("FAIL wr_strobe_cycles got=%0d want=768", nwrc); end
        total++; if (derr !== 0) begin bad++; $display("FAIL wr_addr_din_errs got=%0d want=0", derr); end
        total++; if (nrd !== 0) begin bad++; $display("FAIL wr_mem_rd_seen got=%0d want=0", nrd); end
        total++; if (merr !== 0) begin bad++; $display("FAIL wr_mem_contents got=%0d want=0", merr); end
    endtask

    task automatic test_back_to_back();
        int unsigned gap, ackc, nput, nrd, derr, aerr, both;
        mem_stall = 0;
        repeat (2) @(negedge clk_sys);
        for (int s = 0; s < 4; s++) begin
            do_read(32'(s), 1'b0, gap, ackc, nput, nrd, derr, aerr, both);
            total++; if (gap !== ((s == 0) ? 1 : 2)) begin
                bad++; $display("FAIL b2b_gap s=%0d got=%0d want=%0d", s, gap, (s == 0) ? 1 : 2); end
            total++; if (ackc !== 512 || nput !== 256) begin
                bad++; $display("FAIL b2b_len s=%0d got=%0d/%0d want=512/256", s, ackc, nput); end
            total++; if (derr !== 0 || aerr !== 0 || both !== 0) begin
                bad++; $display("FAIL b2b_errs s=%0d got=%0d/%0d/%0d want=0/0/0", s, derr, aerr, both); end
        end
    endtask

    task automatic test_reset_mid_read();
        int unsigned n, gap, ackc, nput, nrd, derr, aerr, both;
        mem_stall = 0;
        repeat (2) @(negedge clk_sys);
        sd_lba = 32'd1;
        sd_rd  = 1'b1;
        n = 0;
        while (!(sd_buff_wr && sd_buff_addr == 8'd100) && n < 1000) begin
            @(negedge clk_sys);
            n++;
            if (sd_ack) sd_rd = 1'b0;
        end
        sd_rd = 1'b0;
        total++; if (n >= 1000) begin bad++; $display("FAIL mid_reach_word100 got=%0d want=<1000", n); end
        reset = 1'b1;
        @(negedge clk_sys);
        total++; if ({sd_ack, mem_rd, sd_buff_wr} !== 3'b000) begin
            bad++; $display("FAIL mid_reset_abort got=%b want=000", {sd_ack, mem_rd, sd_buff_wr}); end
        total++; if (sd_buff_addr !== 8'h00) begin
            bad++; $display("FAIL mid_reset_index got=%h want=00", sd_buff_addr); end
        reset = 1'b0;
        @(negedge clk_sys);
        do_read(32'd1, 1'b0, gap, ackc, nput, nrd, derr, aerr, both);
        total++; if (gap !== 1 || ackc !== 512 || nput !== 256) begin
            bad++; $display("FAIL mid_reread_len got=%0d/%0d/%0d want=1/512/256", gap, ackc, nput); end
        total++; if (derr !== 0 || aerr !== 0) begin
            bad++; $display("FAIL mid_reread_errs got=%0d/%0d want=0/0", derr, aerr); end
    endtask

    task automatic test_range_and_mount();
        int unsigned gap, ackc, nput, nrd, derr, aerr, both, pulses;
        mem_stall = 0;
        repeat (2) @(negedge clk_sys);
`ifdef SD_SECTOR_RANGE_CHECK_EN
        begin
            int unsigned nrdy, last_rdy, nwrc, merr;
            do_read(32'd64, 1'b1, gap, ackc, nput, nrd, derr, aerr, both);
            total++; if (ackc !== 512 || nput !== 256) begin
                bad++; $display("FAIL oor_rd_len got=%0d/%0d want=512/256", ackc, nput); end
            total++; if (derr !== 0) begin bad++; $display("FAIL oor_rd_zero got=%0d want=0", derr); end
            total++; if (nrd !== 0) begin bad++; $display("FAIL oor_rd_mem_rd got=%0d want=0", nrd); end
            mem_stall = 2;
            repeat (2) @(negedge clk_sys);
            do_write(32'd70, gap, ackc, nrdy, last_rdy, nwrc, derr, nrd);
            merr = 0;
            for (int n = 0; n < 256; n++) if (mem[(6 << 8) + n] !== (16'((6 << 8) + n) ^ 16'h5A5A)) merr++;
            total++; if (ackc !== 768) begin bad++; $display("FAIL oor_wr_ack_cycles got=%0d want=768", ackc); end
            total++; if (nwrc !== 0) begin bad++; $display("FAIL oor_wr_mem_wr got=%0d want=0", nwrc); end
            total++; if (merr !== 0) begin bad++; $display("FAIL oor_wr_mem_touched got=%0d want=0", merr); end
            mem_stall = 0;
        end
`else
        do_read(32'd67, 1'b0, gap, ackc, nput, nrd, derr, aerr, both);
        total++; if (ackc !== 512 || nput !== 256) begin
            bad++; $display("FAIL wrap_rd_len got=%0d/%0d want=512/256", ackc, nput); end
        total++; if (derr !== 0 || aerr !== 0) begin
            bad++; $display("FAIL wrap_rd_errs got=%0d/%0d want=0/0", derr, aerr); end
        total++; if (nrd !== 256) begin bad++; $display("FAIL wrap_rd_mem_rd got=%0d want=256", nrd); end
`endif
        @(negedge clk_sys);
        mount = 1'b1;
        @(negedge clk_sys);
        total++; if (img_mounted !== 1'b1) begin bad++; $display("FAIL mount_pulse got=%b want=1", img_mounted); end
        pulses = 0;
        repeat (6) begin @(negedge clk_sys); if (img_mounted) pulses++; end
        total++; if (pulses !== 0) begin bad++; $display("FAIL mount_one_cycle got=%0d want=0", pulses); end
        mount = 1'b0;
        total++; if (img_size !== 64'd32768) begin bad++; $display("FAIL img_size got=%0d want=32768", img_size); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        for (int i = 0; i < 256; i++) wbuf[i] = '0;
        test_reset();
        test_single_read();
        test_write_stall();
        test_back_to_back();
        test_reset_mid_read();
        test_range_and_mount();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
